minimum_trigger_judge: RTL and testbench



---
 rtl/minimum_trigger_judge_pkg.sv | 29 ++
 rtl/minimum_trigger_judge_tap_delay_line.sv | 28 ++
 rtl/minimum_trigger_judge.sv | 181 ++++++++++++++++++
 tb/tb_minimum_trigger_judge.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/minimum_trigger_judge_pkg.sv
// Shared widths, FSM encoding and DOUT field offsets for minimum_trigger_judge.
// The offsets match the data frame generator's DIN slicing.
package trigger_judge_pkg;

    localparam int unsigned LANES      = 8;
    localparam int unsigned LANE_WIDTH = 16;
    localparam int unsigned DIFF_WIDTH = 13;
    localparam int unsigned ADC_WIDTH  = DIFF_WIDTH - 1;

    localparam int unsigned DOUT_THR_LSB  = 0;
    localparam int unsigned DOUT_BASE_LSB = DOUT_THR_LSB + DIFF_WIDTH;
    localparam int unsigned DOUT_TS_LSB   = DOUT_BASE_LSB + ADC_WIDTH;
    localparam int unsigned DOUT_DATA_LSB = DOUT_TS_LSB + 48;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    // Sign-extend both operands by one bit so the difference can never overflow.
    function automatic logic [DIFF_WIDTH-1:0] sext_diff(
        input logic [ADC_WIDTH-1:0] a,
        input logic [ADC_WIDTH-1:0] b
    );
        return {a[ADC_WIDTH-1], a} - {b[ADC_WIDTH-1], b};
    endfunction

endpackage

// File: rtl/minimum_trigger_judge_tap_delay_line.sv
// Shift register of 2**SEL_WIDTH entries with a runtime-selected output tap.
// Entry k holds the input written k+1 clocks ago; reset fills every entry with ones.
module tap_delay_line #(
    parameter int unsigned WIDTH     = 176,
    parameter int unsigned SEL_WIDTH = 5
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [WIDTH-1:0]     i_din,
    input  logic [SEL_WIDTH-1:0] i_sel,
    output logic [WIDTH-1:0]     o_tap
);

    localparam int unsigned DEPTH = 2 ** SEL_WIDTH;

    logic [DEPTH-1:0][WIDTH-1:0] r_line;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_line <= '1;
        end else begin
            r_line <= {r_line[DEPTH-2:0], i_din};
        end
    end

    assign o_tap = r_line[i_sel];

endmodule

// File: rtl/minimum_trigger_judge.sv
// Per-lane threshold trigger with pre-trigger delay line and free-running timestamp.
// Build option: define NEG_POLARITY_EN to trigger on negative-going pulses.
module minimum_trigger_judge
    import trigger_judge_pkg::*;
#(
    parameter int unsigned TDATA_WIDTH          = 128,
    parameter int unsigned ADC_RESOLUTION_WIDTH = 12,
    parameter int unsigned TIME_STAMP_WIDTH     = 48,
    parameter int unsigned MAX_DELAY_CNT_WIDTH  = 5,
    parameter int unsigned DOUT_WIDTH           = TDATA_WIDTH + TIME_STAMP_WIDTH + 2*ADC_RESOLUTION_WIDTH + 1
) (
    input  logic                            CLK,
    input  logic                            RESETN,
    input  logic [TDATA_WIDTH-1:0]          ADC_TDATA,
    input  logic                            ADC_TVALID,
    input  logic [ADC_RESOLUTION_WIDTH-1:0] BASELINE,
    input  logic [ADC_RESOLUTION_WIDTH:0]   THRESHOLD,
    input  logic [MAX_DELAY_CNT_WIDTH-1:0]  PRE_ACQUISITION_LEN,
    input  logic                            iREADY,
    output logic                            oVALID,
    output logic [DOUT_WIDTH-1:0]           DOUT,
    output logic [TIME_STAMP_WIDTH-1:0]     TIMESTAMP
);

    localparam int unsigned ADC_LSB = LANE_WIDTH - ADC_RESOLUTION_WIDTH;
    localparam int unsigned LINE_W  = TDATA_WIDTH + TIME_STAMP_WIDTH;

    logic [TIME_STAMP_WIDTH-1:0]        r_ts;
    logic [ADC_RESOLUTION_WIDTH-1:0]    r_baseline;
    logic [DIFF_WIDTH-1:0]              r_threshold;
    logic [MAX_DELAY_CNT_WIDTH-1:0]     r_pre_len;

    logic [TDATA_WIDTH-1:0]             r_s1_data;
    logic [TIME_STAMP_WIDTH-1:0]        r_s1_tag;
    logic [LANES-1:0][DIFF_WIDTH-1:0]   r_s1_diff;
    logic                               r_s1_valid;
    logic                               r_s1_ready;
    logic                               r_s2_hit;
    logic                               r_s2_ready;

    logic [LANES-1:0][DIFF_WIDTH-1:0]   w_diff;
    logic [LANES-1:0]                   w_lane_hit;
    logic                               w_hit;
    logic                               w_cfg_load;
    logic [LINE_W-1:0]                  w_tap;
    logic [DOUT_WIDTH-1:0]              w_dout_next;

    state_t                             r_state;
    state_t                             w_state_next;
    logic                               w_valid_next;
    logic                               r_valid;
    logic [DOUT_WIDTH-1:0]              r_dout;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    // Config stays frozen from the first in-flight hit until the FSM is back in IDLE.
    assign w_cfg_load = (r_state == IDLE) && !w_hit && !r_s2_hit;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_baseline  <= '0;
            r_threshold <= '0;
            r_pre_len   <= '0;
        end else if (w_cfg_load) begin
            r_baseline  <= BASELINE;
            r_threshold <= THRESHOLD;
            r_pre_len   <= PRE_ACQUISITION_LEN;
        end
    end

    always_comb begin
        w_diff = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
`ifdef NEG_POLARITY_EN
            w_diff[i] = sext_diff(r_baseline, ADC_TDATA[i*LANE_WIDTH + ADC_LSB +: ADC_RESOLUTION_WIDTH]);
`else
            w_diff[i] = sext_diff(ADC_TDATA[i*LANE_WIDTH + ADC_LSB +: ADC_RESOLUTION_WIDTH], r_baseline);
`endif
        end
    end

    always_comb begin
        w_lane_hit = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_lane_hit[i] = $signed(r_s1_diff[i]) >= $signed(r_threshold);
        end
    end

    assign w_hit = r_s1_valid & (|w_lane_hit);

    // iREADY travels with its sample so the FSM judges each word against its own ready.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_s1_data  <= '0;
            r_s1_tag   <= '0;
            r_s1_diff  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_ready <= 1'b0;
            r_s2_hit   <= 1'b0;
            r_s2_ready <= 1'b0;
        end else begin
            r_s1_data  <= ADC_TDATA;
            r_s1_tag   <= r_ts;
            r_s1_diff  <= w_diff;
            r_s1_valid <= ADC_TVALID;
            r_s1_ready <= iREADY;
            r_s2_hit   <= w_hit;
            r_s2_ready <= r_s1_ready;
        end
    end

    tap_delay_line #(
        .WIDTH     (LINE_W),
        .SEL_WIDTH (MAX_DELAY_CNT_WIDTH)
    ) u_delay (
        .i_clk   (CLK),
        .i_rst_n (RESETN),
        .i_din   ({r_s1_data, r_s1_tag}),
        .i_sel   (r_pre_len),
        .o_tap   (w_tap)
    );

    always_comb begin
        w_dout_next = '0;
        w_dout_next[DOUT_DATA_LSB +: TDATA_WIDTH]         = w_tap[TIME_STAMP_WIDTH +: TDATA_WIDTH];
        w_dout_next[DOUT_TS_LSB +: TIME_STAMP_WIDTH]      = w_tap[0 +: TIME_STAMP_WIDTH];
        w_dout_next[DOUT_BASE_LSB +: ADC_RESOLUTION_WIDTH] = r_baseline;
        w_dout_next[DOUT_THR_LSB +: DIFF_WIDTH]           = r_threshold;
    end

    always_comb begin
        w_state_next = r_state;
        w_valid_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_s2_hit && r_s2_ready) begin
                    w_state_next = ACTIVE;
                    w_valid_next = 1'b1;
                end
            end
            ACTIVE: begin
                if (!r_s2_ready) begin
                    w_state_next = BLOCKED;
                end else if (!r_s2_hit) begin
                    w_state_next = IDLE;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            BLOCKED: begin
                if (r_s2_ready && !r_s2_hit) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_dout  <= '1;
        end else begin
            r_state <= w_state_next;
            r_valid <= w_valid_next;
            r_dout  <= w_dout_next;
        end
    end

    assign oVALID    = r_valid;
    assign DOUT      = r_dout;
    assign TIMESTAMP = r_ts;

endmodule

// File: tb/tb_minimum_trigger_judge.sv
// Table-driven scoreboard bench for minimum_trigger_judge (default positive-polarity build).
module tb_minimum_trigger_judge;

    logic          CLK = 1'b0;
    logic          RESETN = 1'b0;
    logic [127:0]  ADC_TDATA = '0;
    logic          ADC_TVALID = 1'b0;
    logic [11:0]   BASELINE = '0;
    logic [12:0]   THRESHOLD = '0;
    logic [4:0]    PRE_ACQUISITION_LEN = '0;
    logic          iREADY = 1'b1;
    logic          oVALID;
    logic [200:0]  DOUT;
    logic [47:0]   TIMESTAMP;

    always #5 CLK = ~CLK;

    minimum_trigger_judge #(
        .TDATA_WIDTH          (128),
        .ADC_RESOLUTION_WIDTH (12),
        .TIME_STAMP_WIDTH     (48),
        .MAX_DELAY_CNT_WIDTH  (5)
    ) dut (
        .CLK                 (CLK),
        .RESETN              (RESETN),
        .ADC_TDATA           (ADC_TDATA),
        .ADC_TVALID          (ADC_TVALID),
        .BASELINE            (BASELINE),
        .THRESHOLD           (THRESHOLD),
        .PRE_ACQUISITION_LEN (PRE_ACQUISITION_LEN),
        .iREADY              (iREADY),
        .oVALID              (oVALID),
        .DOUT                (DOUT),
        .TIMESTAMP           (TIMESTAMP)
    );

    // Windows/ranges use -1 for "none"; cycle numbers count from reset release.
    typedef struct {
        int base0, base1, base_sw, thr, pre;
        int hv0, h0s, h0e, hv1, h1s, h1e;
        int rlo_s, rlo_e, tvlo;
        int v0s, v0e, vb0, v1s, v1e, vb1;
        int ncyc;
    } scen_t;

    int           n_checks = 0;
    int           n_pass = 0;
    logic [200:0] sb[$];
    logic [47:0]  exp_ts;
    logic [12:0]  cur_thr;
    bit           force_pending = 1'b0;
    logic [47:0]  force_val;

    task automatic check(input string name, input logic [200:0] act, input logic [200:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [127:0] mk_word(input int c, input logic [11:0] v);
        logic [127:0] w;
        logic [31:0]  cc;
        cc = c;
        w = '0;
        for (int i = 0; i < 8; i++) w[16*i +: 4] = cc[4*i +: 4];
        w[16*3+4 +: 12] = v;
        return w;
    endfunction

    task automatic do_reset(input int base, input int thr, input int pre);
        logic [31:0] b, t, p;
        b = base; t = thr; p = pre;
        @(negedge CLK);
        RESETN = 1'b0;
        BASELINE = b[11:0];
        THRESHOLD = t[12:0];
        PRE_ACQUISITION_LEN = p[4:0];
        ADC_TVALID = 1'b0;
        ADC_TDATA = '0;
        iREADY = 1'b1;
        @(negedge CLK);
        check("rst_ovalid", oVALID, 1'b0);
        check("rst_dout", DOUT, {201{1'b1}});
        check("rst_timestamp", TIMESTAMP, 48'd0);
        @(posedge CLK);
        #1 RESETN = 1'b1;
        exp_ts = '0;
        cur_thr = t[12:0];
        sb.delete();
    endtask

    // One clock: check this cycle's outputs, then drive this cycle's inputs.
    task automatic step(input int c, input logic [11:0] lval, input logic tv, input logic rdy,
                        input logic [11:0] base, input logic exp_v, input logic push,
                        input logic [11:0] exp_base);
        logic [127:0] w;
        logic [200:0] e;
        @(negedge CLK);
        if (force_pending) begin
            force dut.r_ts = force_val;
            #1 release dut.r_ts;
            exp_ts = force_val;
            force_pending = 1'b0;
        end
        check($sformatf("timestamp@%0d", c), TIMESTAMP, exp_ts);
        check($sformatf("ovalid@%0d", c), oVALID, exp_v);
        if (oVALID === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL dout_unexpected@%0d: got oVALID=1 with DOUT %h, expected no output", c, DOUT);
            end else begin
                e = sb.pop_front();
                check($sformatf("dout@%0d", c), DOUT, e);
            end
        end
        w = mk_word(c, lval);
        ADC_TDATA = w;
        ADC_TVALID = tv;
        iREADY = rdy;
        BASELINE = base;
        if (push) sb.push_back({w, exp_ts, exp_base, cur_thr});
        exp_ts = exp_ts + 48'd1;
    endtask

    function automatic bit in_rng(input int c, input int lo, input int hi);
        return (lo >= 0) && (c >= lo) && (c <= hi);
    endfunction

    task automatic run_scen(input int idx, input scen_t s);
        logic [31:0] lv, bs, eb;
        int o;
        do_reset(s.base0, s.thr, s.pre);
        for (int c = 0; c < s.ncyc; c++) begin
            lv = 0;
            if (in_rng(c, s.h0s, s.h0e)) lv = s.hv0;
            if (in_rng(c, s.h1s, s.h1e)) lv = s.hv1;
            bs = (s.base_sw >= 0 && c >= s.base_sw) ? s.base1 : s.base0;
            o = c + s.pre + 3;
            eb = in_rng(o, s.v0s, s.v0e) ? s.vb0 : s.vb1;
            step(c, lv[11:0], (c >= 2) && (c != s.tvlo), !in_rng(c, s.rlo_s, s.rlo_e), bs[11:0],
                 in_rng(c, s.v0s, s.v0e) || in_rng(c, s.v1s, s.v1e),
                 in_rng(o, s.v0s, s.v0e) || in_rng(o, s.v1s, s.v1e), eb[11:0]);
        end
        check($sformatf("sb_empty_s%0d", idx), sb.size(), 0);
    endtask

    scen_t tbl[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{100, 100, -1, 50, 0, 150, 10, 10, 0, -1, -1, -1, -1, -1, 13, 13, 100, -1, -1, 0, 20};
        tbl[1] = '{100, 100, -1, 50, 0, 149, 10, 10, 0, -1, -1, -1, -1, -1, -1, -1, 0, -1, -1, 0, 20};
        tbl[2] = '{100, 100, -1, 50, 4, 150, 20, 24, 0, -1, -1, -1, -1, -1, 23, 27, 100, -1, -1, 0, 35};
        tbl[3] = '{100, 100, -1, 50, 0, 150, 30, 40, 150, 50, 50, 35, 36, -1, 33, 37, 100, 53, 53, 100, 60};
        tbl[4] = '{100, 0, 32, 50, 0, 150, 30, 34, 60, 50, 50, -1, -1, -1, 33, 37, 100, 53, 53, 0, 60};
        tbl[5] = '{100, 100, -1, 50, 0, 150, 10, 10, 0, -1, -1, -1, -1, 10, -1, -1, 0, -1, -1, 0, 20};
        tbl[6] = '{100, 100, -1, 50, 31, 150, 40, 40, 0, -1, -1, -1, -1, -1, 43, 43, 100, -1, -1, 0, 50};
        tbl[7] = '{100, 100, -1, 50, 0, 150, 10, 12, 0, -1, -1, 10, 10, -1, 14, 15, 100, -1, -1, 0, 20};

        for (int i = 0; i < 8; i++) run_scen(i, tbl[i]);

        // Timestamp wrap: counter loaded to 2**48-2 in cycle 5, hits tagged 2**48-1, 0, 1.
        do_reset(100, 50, 0);
        for (int c = 0; c < 15; c++) begin
            if (c == 5) begin
                force_val = 48'hFFFF_FFFF_FFFE;
                force_pending = 1'b1;
            end
            step(c, (c >= 6 && c <= 8) ? 12'd150 : 12'd0, c >= 2, 1'b1, 12'd100,
                 c >= 9 && c <= 11, c >= 6 && c <= 8, 12'd100);
        end
        check("sb_empty_wrap", sb.size(), 0);

        // Asynchronous reset in the middle of a trigger window.
        do_reset(100, 50, 0);
        for (int c = 0; c < 20; c++) begin
            step(c, (c >= 15) ? 12'd150 : 12'd0, c >= 2, 1'b1, 12'd100,
                 c >= 18, c >= 15 && c <= 16, 12'd100);
        end
        check("sb_empty_prereset", sb.size(), 0);
        @(negedge CLK);
        check("ovalid_before_reset", oVALID, 1'b1);
        RESETN = 1'b0;
        #1;
        check("ovalid_async_reset", oVALID, 1'b0);
        check("timestamp_async_reset", TIMESTAMP, 48'd0);
        check("dout_async_reset", DOUT, {201{1'b1}});
        #20;
        RESETN = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
